// File: rtl/cnn_seq_if.sv
// Control/status bundle between the host-side controller and the CNN layer sequencer.
// The sequencer binds to the slave modport; the host or bench binds to the master modport.
interface cnn_seq_if #(
  parameter int unsigned LW         = 4,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  start_cnn;
  logic [LW-1:0]         num_layers;
  logic                  step_mode;
  logic                  step;
  logic                  clear_error;
  logic                  layer_done;
  logic                  wr_layer_done;
  logic [LW-1:0]         count_layer;
  logic [ADDR_WIDTH-1:0] rd_base_addr;
  logic [ADDR_WIDTH-1:0] wr_base_addr;
  logic                  start_read;
  logic                  start_layer;
  logic                  busy;
  logic                  done_cnn;
  logic                  error;

  modport master (
    output start_cnn, num_layers, step_mode, step, clear_error, layer_done, wr_layer_done,
    input  count_layer, rd_base_addr, wr_base_addr, start_read, start_layer, busy, done_cnn,
           error
  );

  modport slave (
    input  start_cnn, num_layers, step_mode, step, clear_error, layer_done, wr_layer_done,
    output count_layer, rd_base_addr, wr_base_addr, start_read, start_layer, busy, done_cnn,
           error
  );
endinterface

// File: rtl/cnn_layer_sequencer.sv
// Walks up to NUM_LAYER layers, pulses the read DMA and compute core per layer, ping-pongs
// feature-map buffers, supports single-step pausing and a per-layer watchdog.
module cnn_layer_sequencer #(
  parameter int unsigned           NUM_LAYER      = 13,
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] IFM_BASE       = 32'h1000_0000,
  parameter logic [ADDR_WIDTH-1:0] PING_BASE      = 32'h2000_0000,
  parameter logic [ADDR_WIDTH-1:0] PONG_BASE      = 32'h3000_0000,
  parameter logic [ADDR_WIDTH-1:0] OUT_BASE       = 32'h4000_0000,
  parameter int unsigned           TIMEOUT_CYCLES = 0,
  parameter int unsigned           LW             = $clog2(NUM_LAYER + 1)
) (
  input logic     M_AXI_ACLK,
  input logic     M_AXI_ARESETN,
  cnn_seq_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StCfg, StRun, StPause, StDone, StError} state_e;

  state_e                state_q, state_d;
  logic [LW-1:0]         n_q, n_d;
  logic [LW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d, wr_q, wr_d;
  logic                  c_done_q, c_done_d, w_done_q, w_done_d;
  logic                  start_q, start_d;
  logic [31:0]           wdog_q, wdog_d;

  logic c_set, w_set, both_done, last_layer, timeout;

  // Flags include this cycle's pulses so completion is seen without an extra cycle.
  assign c_set      = c_done_q | bus.layer_done;
  assign w_set      = w_done_q | bus.wr_layer_done;
  assign both_done  = c_set & w_set;
  assign last_layer = (count_q == n_q - LW'(1));
  assign timeout    = (TIMEOUT_CYCLES != 0) && (wdog_q == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    count_d  = count_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    c_done_d = c_done_q;
    w_done_d = w_done_q;
    wdog_d   = wdog_q;
    start_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start_cnn) begin
          n_d     = bus.num_layers;
          count_d = '0;
          if (bus.num_layers == '0 || bus.num_layers > LW'(NUM_LAYER)) state_d = StError;
          else                                                          state_d = StCfg;
        end
      end
      StCfg: begin
        if (count_q == '0)     rd_d = IFM_BASE;
        else if (!count_q[0])  rd_d = PONG_BASE;
        else                   rd_d = PING_BASE;
        if (last_layer)        wr_d = OUT_BASE;
        else if (!count_q[0])  wr_d = PING_BASE;
        else                   wr_d = PONG_BASE;
        c_done_d = 1'b0;
        w_done_d = 1'b0;
        wdog_d   = '0;
        start_d  = 1'b1;
        state_d  = StRun;
      end
      StRun: begin
        c_done_d = c_set;
        w_done_d = w_set;
        wdog_d   = wdog_q + 32'd1;
        if (both_done) begin
          if (last_layer)         state_d = StDone;
          else if (bus.step_mode) state_d = StPause;
          else begin
            count_d = count_q + LW'(1);
            state_d = StCfg;
          end
        end else if (timeout) begin
          state_d = StError;
        end
      end
      StPause: begin
        if (bus.step) begin
          count_d = count_q + LW'(1);
          state_d = StCfg;
        end
      end
      StDone:  state_d = StIdle;
      StError: if (bus.clear_error) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q  <= StIdle;
      n_q      <= '0;
      count_q  <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      c_done_q <= 1'b0;
      w_done_q <= 1'b0;
      start_q  <= 1'b0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      count_q  <= count_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      c_done_q <= c_done_d;
      w_done_q <= w_done_d;
      start_q  <= start_d;
      wdog_q   <= wdog_d;
    end
  end

  assign bus.count_layer  = count_q;
  assign bus.rd_base_addr = rd_q;
  assign bus.wr_base_addr = wr_q;
  assign bus.start_read   = start_q;
  assign bus.start_layer  = start_q;
  assign bus.busy         = (state_q == StCfg) || (state_q == StRun) || (state_q == StPause);
  assign bus.done_cnn     = (state_q == StDone);
  assign bus.error        = (state_q == StError);

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed plus randomized bench for cnn_layer_sequencer; expected addresses, counts and pulse
// timing come from the reference functions and cycle accounting below.
module tb_cnn_layer_sequencer;
  localparam int unsigned LW = 4;
  localparam logic [31:0] IFM  = 32'h1000_0000;
  localparam logic [31:0] PING = 32'h2000_0000;
  localparam logic [31:0] PONG = 32'h3000_0000;
  localparam logic [31:0] OUTB = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   n_rd = 0, n_ly = 0, n_dn = 0;

  always #5 clk = ~clk;

  cnn_seq_if #(.LW(LW), .ADDR_WIDTH(32)) bus ();

  cnn_layer_sequencer #(.TIMEOUT_CYCLES(100)) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESETN(rst_n),
    .bus          (bus)
  );

  always @(negedge clk) begin
    if (bus.start_read)  n_rd++;
    if (bus.start_layer) n_ly++;
    if (bus.done_cnn)    n_dn++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input int l);
    if (l == 0)          return IFM;
    else if (l % 2 == 0) return PONG;
    else                 return PING;
  endfunction

  function automatic logic [31:0] ref_wr(input int l, input int n);
    if (l == n - 1)      return OUTB;
    else if (l % 2 == 0) return PING;
    else                 return PONG;
  endfunction

  // Ends at T+2, the cycle where the first start pulse must be visible.
  task automatic start_run(input int n, input bit stepm);
    bus.num_layers = LW'(n);
    bus.step_mode  = stepm;
    bus.start_cnn  = 1'b1;
    tick();
    bus.start_cnn  = 1'b0;
    chk("cfg_busy", 64'(bus.busy), 64'd1);
    tick();
  endtask

  // Entered at the layer's start cycle; returns at D+1 (cycle after the later done pulse).
  task automatic do_layer(input int l, input int n, input int dc, input int dw);
    int m;
    chk("start_read", 64'(bus.start_read), 64'd1);
    chk("start_layer", 64'(bus.start_layer), 64'd1);
    chk("count_layer", 64'(bus.count_layer), 64'(l));
    chk("rd_base", 64'(bus.rd_base_addr), 64'(ref_rd(l)));
    chk("wr_base", 64'(bus.wr_base_addr), 64'(ref_wr(l, n)));
    m = (dc > dw) ? dc : dw;
    for (int k = 1; k <= m; k++) begin
      tick();
      if (k == 1) chk("start_one_cycle", 64'(bus.start_read), 64'd0);
      bus.layer_done    = (k == dc);
      bus.wr_layer_done = (k == dw);
    end
    tick();
    bus.layer_done    = 1'b0;
    bus.wr_layer_done = 1'b0;
  endtask

  task automatic run_seq(input int n, input int fixed_dc, input int fixed_dw);
    int rd0, ly0, dn0, dc, dw;
    rd0 = n_rd; ly0 = n_ly; dn0 = n_dn;
    start_run(n, 1'b0);
    for (int l = 0; l < n; l++) begin
      dc = (fixed_dc > 0) ? fixed_dc : int'($urandom_range(1, 12));
      dw = (fixed_dw > 0) ? fixed_dw : int'($urandom_range(1, 12));
      do_layer(l, n, dc, dw);
      if (l < n - 1) begin
        chk("gap_busy", 64'(bus.busy), 64'd1);
        tick();
      end else begin
        chk("done_pulse", 64'(bus.done_cnn), 64'd1);
        tick();
        chk("done_one_cycle", 64'(bus.done_cnn), 64'd0);
        chk("idle_busy", 64'(bus.busy), 64'd0);
        chk("final_count", 64'(bus.count_layer), 64'(n - 1));
      end
    end
    chk("n_start_read", 64'(n_rd - rd0), 64'(n));
    chk("n_start_layer", 64'(n_ly - ly0), 64'(n));
    chk("n_done_cnn", 64'(n_dn - dn0), 64'd1);
  endtask

  initial begin
    int rd0, dn0, n;
    bus.start_cnn = 1'b0; bus.num_layers = '0; bus.step_mode = 1'b0; bus.step = 1'b0;
    bus.clear_error = 1'b0; bus.layer_done = 1'b0; bus.wr_layer_done = 1'b0;
    #12;
    chk("rst_count", 64'(bus.count_layer), 64'd0);
    chk("rst_rd", 64'(bus.rd_base_addr), 64'd0);
    chk("rst_wr", 64'(bus.wr_base_addr), 64'd0);
    chk("rst_flags", 64'({bus.start_read, bus.start_layer, bus.busy, bus.done_cnn, bus.error}),
        64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic three-layer run, then same-cycle and write-first completion orders.
    run_seq(3, 10, 10);
    tick();
    run_seq(2, 3, 3);
    tick();
    run_seq(2, 8, 3);
    tick();

    // Single-step: hold in PAUSE, then step launches layer 1 two cycles later.
    rd0 = n_rd;
    start_run(2, 1'b1);
    do_layer(0, 2, 4, 6);
    for (int i = 0; i < 50; i++) begin
      if (i == 0 || i == 49) chk("pause_busy", 64'(bus.busy), 64'd1);
      tick();
    end
    chk("pause_no_start", 64'(n_rd - rd0), 64'd1);
    chk("pause_count", 64'(bus.count_layer), 64'd0);
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    tick();
    do_layer(1, 2, 2, 5);
    chk("step_done", 64'(bus.done_cnn), 64'd1);
    tick();
    tick();

    // Watchdog on layer 1: write-back arrives, compute never does.
    start_run(2, 1'b0);
    do_layer(0, 2, 5, 5);
    tick();
    chk("wd_start", 64'(bus.start_layer), 64'd1);
    for (int k = 1; k <= 99; k++) begin
      tick();
      bus.wr_layer_done = (k == 3);
      if (k == 99) chk("wd_not_yet", 64'(bus.error), 64'd0);
    end
    tick();
    chk("wd_error", 64'(bus.error), 64'd1);
    chk("wd_count", 64'(bus.count_layer), 64'd1);
    chk("wd_busy", 64'(bus.busy), 64'd0);
    rd0 = n_rd;
    bus.num_layers = LW'(1);
    bus.start_cnn = 1'b1;
    tick();
    bus.start_cnn = 1'b0;
    tick();
    chk("err_ignores_start", 64'(bus.error), 64'd1);
    chk("err_no_pulse", 64'(n_rd - rd0), 64'd0);
    bus.clear_error = 1'b1;
    tick();
    bus.clear_error = 1'b0;
    chk("err_cleared", 64'(bus.error), 64'd0);
    run_seq(1, 3, 4);
    tick();

    // Illegal layer counts and a stray done in IDLE.
    rd0 = n_rd;
    bus.layer_done = 1'b1;
    tick();
    bus.layer_done = 1'b0;
    tick();
    chk("stray_idle_busy", 64'(bus.busy), 64'd0);
    for (int b = 0; b < 2; b++) begin
      bus.num_layers = (b == 0) ? LW'(0) : LW'(14);
      bus.start_cnn = 1'b1;
      tick();
      bus.start_cnn = 1'b0;
      chk("bad_n_error", 64'(bus.error), 64'd1);
      tick();
      bus.clear_error = 1'b1;
      tick();
      bus.clear_error = 1'b0;
      chk("bad_n_cleared", 64'(bus.error), 64'd0);
    end
    chk("bad_n_no_start", 64'(n_rd - rd0), 64'd0);

    // Asynchronous reset during layer 1.
    dn0 = n_dn;
    start_run(3, 1'b0);
    do_layer(0, 3, 5, 5);
    tick();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 64'(bus.count_layer), 64'd0);
    chk("arst_addr", 64'({bus.rd_base_addr, bus.wr_base_addr}), 64'd0);
    chk("arst_flags", 64'({bus.start_read, bus.start_layer, bus.busy, bus.done_cnn, bus.error}),
        64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst_no_done", 64'(n_dn - dn0), 64'd0);
    run_seq(2, 4, 7);
    tick();

    // Randomized runs against the address/count model.
    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(1, 13));
      run_seq(n, 0, 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=hang expected=finish");
    $fatal(1, "bench time limit");
  end

endmodule
